// File: rtl/store_buffer.sv
// store_buffer: in-order store write buffer in front of a single-port data memory.
// Optional feature macro STB_FWD_EN: an lw hitting a buffered sw at the same address is forwarded.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [2:0]            AddrMode,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  stall,
    output logic                  empty,
    output logic [2:0]            mem_AddrMode,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    input  logic [DATA_WIDTH-1:0] mem_RD
);
    localparam int         PW      = $clog2(DEPTH);
    localparam logic [2:0] MODE_LW = 3'b010;
    localparam logic [2:0] MODE_SW = 3'b111;

    logic [2:0]            mode_q [DEPTH];
    logic [2:0]            mode_d [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [PW:0]           count_q, count_d;

    logic                  req_store, full, hazard, fwd, take_port, enq, drain;
    logic [PW-1:0]         idx;
`ifdef STB_FWD_EN
    logic                  young_sw;
    logic [DATA_WIDTH-1:0] fwd_data;
`endif

    function automatic logic [ADDR_WIDTH:0] acc_size(input logic [2:0] m);
        case (m)
            3'b000, 3'b011, 3'b101: acc_size = (ADDR_WIDTH+1)'(1);
            3'b001, 3'b100, 3'b110: acc_size = (ADDR_WIDTH+1)'(2);
            default:                acc_size = (ADDR_WIDTH+1)'(4);
        endcase
    endfunction

    // Byte ranges compared one bit wider than the address so the end never wraps.
    function automatic logic overlaps(input logic [2:0] m1, input logic [ADDR_WIDTH-1:0] a1,
                                      input logic [2:0] m2, input logic [ADDR_WIDTH-1:0] a2);
        logic [ADDR_WIDTH:0] lo1, lo2;
        lo1 = {1'b0, a1};
        lo2 = {1'b0, a2};
        overlaps = (lo1 < lo2 + acc_size(m2)) && (lo2 < lo1 + acc_size(m1));
    endfunction

    // Walk oldest to youngest so the last hit is the youngest overlapping entry.
    always_comb begin
        hazard = 1'b0;
        idx    = head_q;
`ifdef STB_FWD_EN
        young_sw = 1'b0;
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) && overlaps(AddrMode, A, mode_q[idx], addr_q[idx])) begin
                hazard = 1'b1;
`ifdef STB_FWD_EN
                young_sw = (mode_q[idx] == MODE_SW) && (addr_q[idx] == A);
                fwd_data = data_q[idx];
`endif
            end
        end
    end

    always_comb begin
        req_store = AddrMode[2] & (AddrMode[1] | AddrMode[0]);
        full      = (count_q == (PW+1)'(DEPTH));
`ifdef STB_FWD_EN
        fwd = req_valid & (AddrMode == MODE_LW) & hazard & young_sw;
        RD  = fwd ? fwd_data : mem_RD;
`else
        fwd = 1'b0;
        RD  = mem_RD;
`endif
        stall     = req_valid & (req_store ? full : (hazard & ~fwd));
        take_port = req_valid & ~stall & ~fwd;
        enq       = take_port & req_store;
        drain     = ~take_port & (count_q != '0);
        empty     = (count_q == '0);

        // An accepted store owns the port but issues nothing, leaving a harmless read.
        mem_AddrMode = MODE_LW;
        mem_A        = '0;
        mem_WD       = '0;
        if (take_port && !req_store) begin
            mem_AddrMode = AddrMode;
            mem_A        = A;
            mem_WD       = WD;
        end else if (drain) begin
            mem_AddrMode = mode_q[head_q];
            mem_A        = addr_q[head_q];
            mem_WD       = data_q[head_q];
        end
    end

    always_comb begin
        mode_d = mode_q;
        addr_d = addr_q;
        data_d = data_q;
        if (enq) begin
            mode_d[tail_q] = AddrMode;
            addr_d[tail_q] = A;
            data_d[tail_q] = WD;
        end
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + (PW+1)'(enq) - (PW+1)'(drain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mode_q[i] <= MODE_LW;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
